// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module : viterbi_pkg
// Brief  : Shared trellis tables and helpers for the rate-1/2, 8-state Viterbi
//          decoder (ACS stage and traceback unit).
// Rev    : 1.0
// ============================================================================
package viterbi_pkg;

    localparam int NSTATES  = 8;
    localparam int PM_W_DEF = 8;

    typedef logic [PM_W_DEF-1:0] pm_t;
    typedef logic [2:0]          state_t;

    // Predecessor states of each state, selected by the decision bit
    localparam state_t PRED0 [NSTATES] = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd1, 3'd2, 3'd5, 3'd6};
    localparam state_t PRED1 [NSTATES] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd0, 3'd3, 3'd4, 3'd7};

    localparam logic [1:0] CW0 [NSTATES] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
    localparam logic [1:0] CW1 [NSTATES] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01};

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acs_butterfly.sv
`default_nettype none
// ============================================================================
// Module : acs_butterfly
// Brief  : Add-compare-select for one trellis state: two candidate metrics in,
//          surviving metric (one guard bit wider) and decision bit out.
// Rev    : 1.0
// ============================================================================
module acs_butterfly #(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W:0]   pm_new,
    output logic            dec
);

    logic [PM_W:0] w_cand0;
    logic [PM_W:0] w_cand1;

    assign w_cand0 = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    assign w_cand1 = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};

    // Ties resolve to the PRED0 branch
    assign dec    = (w_cand1 < w_cand0);
    assign pm_new = dec ? w_cand1 : w_cand0;

endmodule
`default_nettype wire

// File: rtl/acs_unit.sv
`default_nettype none
// ============================================================================
// Module : acs_unit
// Brief  : ACS stage of the 8-state hard-decision Viterbi decoder: metric
//          update with normalisation, argmin, survivor-bank address/bank.
// Rev    : 1.0
// ============================================================================
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W    = 8,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int INIT_PM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              valid_in,
    input  logic [1:0]        sym,
    output logic [7:0]        d_out,
    output logic              valid_out,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              bank_sel,
    output logic              bank_full,
    output logic [2:0]        best_state
);

    localparam logic [PM_W-1:0]   c_init = PM_W'(INIT_PM);
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [PM_W-1:0]    r_pm  [NSTATES];
    logic [PM_W:0]      w_sum [NSTATES];
    logic [PM_W-1:0]    w_new [NSTATES];
    logic [NSTATES-1:0] w_dec;
    logic               w_norm;
    logic               w_ovf;
    logic               w_fire;
    logic [2:0]         w_best;
    logic [PM_W-1:0]    w_min;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_bank;

    assign w_fire = enable & valid_in;

    generate
        for (genvar s = 0; s < NSTATES; s++) begin : g_acs
            acs_butterfly #(.PM_W(PM_W)) u_bfly (
                .pm0    (r_pm[PRED0[s]]),
                .pm1    (r_pm[PRED1[s]]),
                .bm0    (hamming2(sym, CW0[s])),
                .bm1    (hamming2(sym, CW1[s])),
                .pm_new (w_sum[s]),
                .dec    (w_dec[s])
            );
        end
    endgenerate

    // Subtracting 2**(PM_W-1) from every metric preserves all differences
    always_comb begin
        w_norm = 1'b1;
        w_ovf  = 1'b0;
        for (int s = 0; s < NSTATES; s++) begin
            w_norm = w_norm & w_sum[s][PM_W-1];
            w_ovf  = w_ovf | w_sum[s][PM_W];
        end
    end

    always_comb begin
        for (int s = 0; s < NSTATES; s++) begin
            w_new[s] = w_sum[s][PM_W-1:0];
            if (w_norm) begin
                w_new[s][PM_W-1] = 1'b0;
            end
        end
    end

    // Strict compare keeps the lowest index on ties
    always_comb begin
        w_best = 3'd0;
        w_min  = w_new[0];
        for (int s = 1; s < NSTATES; s++) begin
            if (w_new[s] < w_min) begin
                w_min  = w_new[s];
                w_best = 3'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSTATES; s++) begin
                r_pm[s] <= (s == 0) ? '0 : c_init;
            end
            d_out      <= '0;
            valid_out  <= 1'b0;
            wr_addr    <= '0;
            bank_sel   <= 1'b0;
            bank_full  <= 1'b0;
            best_state <= '0;
            r_cnt      <= '0;
            r_bank     <= 1'b0;
        end else begin
            valid_out <= w_fire;
            bank_full <= w_fire && (r_cnt == c_last);
            if (w_fire) begin
                for (int s = 0; s < NSTATES; s++) begin
                    r_pm[s] <= w_new[s];
                end
                d_out      <= w_dec;
                best_state <= w_best;
                wr_addr    <= r_cnt;
                bank_sel   <= r_bank;
                r_cnt      <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    r_bank <= ~r_bank;
                end
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst) w_fire |-> !w_ovf);

endmodule
`default_nettype wire
